// File: rtl/morse_pkg.sv
// Shared definitions for the morse capture and playback paths.
// Holds the 2-bit symbol encoding, character geometry, the capture FSM state type
// and a helper that writes one symbol into a packed 5-slot character word.
package morse_pkg;

  localparam logic [1:0] SYM_NONE  = 2'b00;
  localparam logic [1:0] SYM_SHORT = 2'b01;
  localparam logic [1:0] SYM_LONG  = 2'b10;

  localparam int unsigned MAX_SYMBOLS = 5;
  localparam int unsigned MORSE_W     = 10;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StGap,
    StHold
  } morse_state_e;

  // Slot 0 (first symbol) occupies the two MSBs; slot 4 the two LSBs.
  function automatic logic [MORSE_W-1:0] slot_put(input logic [MORSE_W-1:0] word,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [1:0]         sym);
    logic [MORSE_W-1:0] res;
    res = word;
    for (int unsigned i = 0; i < MAX_SYMBOLS; i++) begin
      if (idx == IDX_W'(i)) begin
        res[MORSE_W-1-2*i -: 2] = sym;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset, clears both flops
//   d_i     - asynchronous input
//   q_o     - synchronized output (two cycles of latency)
module sync2 (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/morse_capture.sv
// Morse key capture: times key presses and gaps on the synchronized key and packs up to
// five short/long symbols into a 10-bit character, presented with valid until acked.
// Ports:
//   clk_i      - clock
//   reset_i    - synchronous active-high reset
//   key_i      - asynchronous telegraph key, 1 = pressed
//   ack_i      - consumer accepts the character (only looked at while valid_o = 1)
//   morse_o    - captured character, slot 0 in [9:8] ... slot 4 in [1:0]
//   valid_o    - morse_o / overflow_o hold a complete character
//   overflow_o - the character had more than five symbols, extras dropped
//   busy_o     - a character is being assembled
module morse_capture
  import morse_pkg::*;
#(
  parameter int unsigned MIN_PRESS = 2,
  parameter int unsigned LONG_MIN  = 8,
  parameter int unsigned CHAR_GAP  = 16,
  parameter int unsigned CNT_W     = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_i,
  input  logic               ack_i,
  output logic [MORSE_W-1:0] morse_o,
  output logic               valid_o,
  output logic               overflow_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinPress = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] LongMin  = CNT_W'(LONG_MIN);
  // The falling-edge cycle is the first low cycle but leaves the count cleared, so the
  // CHAR_GAP-th low cycle is seen in GAP with the count at CHAR_GAP-2.
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(CHAR_GAP - 2);
  localparam logic [IDX_W-1:0] IdxMax   = IDX_W'(MAX_SYMBOLS);

  logic key_s;

  sync2 u_key_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (key_i),
    .q_o    (key_s)
  );

  morse_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MORSE_W-1:0] morse_q, morse_d;
  logic               ovf_q, ovf_d;
  logic               key_prev_q;
  // Masks edges while the synchronizer refills after reset, so a key held through
  // reset does not look like a fresh press.
  logic [1:0]         settle_q, settle_d;

  logic             key_rise;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       sym;

  assign key_rise = key_s & ~key_prev_q & (settle_q == 2'd0);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    morse_d  = morse_q;
    ovf_d    = ovf_q;
    settle_d = (settle_q != 2'd0) ? settle_q - 2'd1 : settle_q;
    sym      = SYM_NONE;

    unique case (state_q)
      StIdle: begin
        if (key_rise) begin
          state_d = StPress;
          cnt_d   = CntOne;
          idx_d   = '0;
        end
      end
      StPress: begin
        if (key_s) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = StGap;
          cnt_d   = '0;
          if (cnt_q >= MinPress) begin
            sym = (cnt_q >= LongMin) ? SYM_LONG : SYM_SHORT;
            if (idx_q < IdxMax) begin
              morse_d = slot_put(morse_q, idx_q, sym);
              idx_d   = idx_q + IDX_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (key_s) begin
          state_d = StPress;
          cnt_d   = CntOne;
        end else if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = (idx_q != '0) ? StHold : StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        if (ack_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
          morse_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      morse_q    <= '0;
      ovf_q      <= 1'b0;
      key_prev_q <= 1'b0;
      settle_q   <= 2'd3;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      morse_q    <= morse_d;
      ovf_q      <= ovf_d;
      key_prev_q <= key_s;
      settle_q   <= settle_d;
    end
  end

  assign valid_o    = (state_q == StHold);
  assign overflow_o = valid_o & ovf_q;
  assign busy_o     = (state_q == StPress) || (state_q == StGap);
  assign morse_o    = morse_q;

endmodule

// File: tb/tb_morse_capture.sv
// Directed self-checking bench for morse_capture with the default timing parameters.
module tb_morse_capture;

  logic       clk_i;
  logic       reset_i;
  logic       key_i;
  logic       ack_i;
  logic [9:0] morse_o;
  logic       valid_o;
  logic       overflow_o;
  logic       busy_o;

  int errs;
  int checks;

  morse_capture #(
    .MIN_PRESS(2),
    .LONG_MIN (8),
    .CHAR_GAP (16),
    .CNT_W    (24)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .key_i     (key_i),
    .ack_i     (ack_i),
    .morse_o   (morse_o),
    .valid_o   (valid_o),
    .overflow_o(overflow_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic press(input int n);
    key_i = 1'b1;
    tick(n);
    key_i = 1'b0;
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
  endtask

  logic saw_valid;
  logic saw_busy;

  initial begin
    errs    = 0;
    checks  = 0;
    reset_i = 1'b1;
    key_i   = 1'b0;
    ack_i   = 1'b0;
    tick(3);
    reset_i = 1'b0;
    check_eq("rst_morse", 32'(morse_o), 32'h0);
    check_eq("rst_valid", 32'(valid_o), 32'h0);
    check_eq("rst_ovf", 32'(overflow_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    tick(4);

    // Short then long; ack held high during assembly must be ignored.
    ack_i = 1'b1;
    press(3);
    tick(4);
    press(10);
    tick(17);
    ack_i = 1'b0;
    check_eq("c1_valid_early", 32'(valid_o), 32'h0);
    check_eq("c1_busy", 32'(busy_o), 32'h1);
    tick(1);
    check_eq("c1_valid", 32'(valid_o), 32'h1);
    check_eq("c1_morse", 32'(morse_o), 32'(10'b0110000000));
    check_eq("c1_ovf", 32'(overflow_o), 32'h0);
    check_eq("c1_busy_hold", 32'(busy_o), 32'h0);
    tick(5);
    check_eq("c1_valid_held", 32'(valid_o), 32'h1);
    check_eq("c1_morse_held", 32'(morse_o), 32'(10'b0110000000));
    ack_pulse();
    check_eq("c1_valid_ack", 32'(valid_o), 32'h0);
    check_eq("c1_morse_clr", 32'(morse_o), 32'h0);
    tick(4);

    // Six shorts: five stored, sixth dropped with overflow.
    for (int i = 0; i < 6; i++) begin
      press(3);
      tick(4);
    end
    tick(14);
    check_eq("ovf_valid", 32'(valid_o), 32'h1);
    check_eq("ovf_morse", 32'(morse_o), 32'(10'b0101010101));
    check_eq("ovf_flag", 32'(overflow_o), 32'h1);
    ack_pulse();
    check_eq("ovf_flag_clr", 32'(overflow_o), 32'h0);
    tick(4);

    // Single-cycle glitch never produces a character.
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    press(1);
    for (int i = 0; i < 22; i++) begin
      tick(1);
      saw_valid |= valid_o;
      saw_busy  |= busy_o;
    end
    check_eq("glitch_valid", 32'(saw_valid), 32'h0);
    check_eq("glitch_busy_seen", 32'(saw_busy), 32'h1);
    check_eq("glitch_busy_end", 32'(busy_o), 32'h0);

    // LONG_MIN boundary.
    press(7);
    tick(18);
    check_eq("p7_morse", 32'(morse_o), 32'(10'b0100000000));
    ack_pulse();
    tick(3);
    press(8);
    tick(18);
    check_eq("p8_morse", 32'(morse_o), 32'(10'b1000000000));
    ack_pulse();
    tick(3);

    // CHAR_GAP boundary: 15 low cycles keep the character open, 16 close it.
    press(3);
    tick(15);
    press(3);
    tick(18);
    check_eq("g15_valid", 32'(valid_o), 32'h1);
    check_eq("g15_morse", 32'(morse_o), 32'(10'b0101000000));
    ack_pulse();
    tick(3);
    press(3);
    tick(16);
    press(3);
    tick(18);
    check_eq("g16_valid", 32'(valid_o), 32'h1);
    check_eq("g16_morse", 32'(morse_o), 32'(10'b0100000000));
    ack_pulse();
    tick(20);
    check_eq("g16_after_busy", 32'(busy_o), 32'h0);
    check_eq("g16_after_valid", 32'(valid_o), 32'h0);

    // Key pressed during HOLD and still down at ack.
    press(3);
    tick(18);
    key_i = 1'b1;
    tick(5);
    check_eq("hk_valid", 32'(valid_o), 32'h1);
    check_eq("hk_morse", 32'(morse_o), 32'(10'b0100000000));
    ack_pulse();
    check_eq("hk_valid_ack", 32'(valid_o), 32'h0);
    tick(10);
    check_eq("hk_busy_held", 32'(busy_o), 32'h0);
    key_i = 1'b0;
    tick(20);
    check_eq("hk_valid_end", 32'(valid_o), 32'h0);
    check_eq("hk_busy_end", 32'(busy_o), 32'h0);

    // Reset mid-press after two stored symbols, key held across reset.
    press(3);
    tick(4);
    press(3);
    tick(4);
    key_i = 1'b1;
    tick(4);
    check_eq("mr_busy_pre", 32'(busy_o), 32'h1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check_eq("mr_morse", 32'(morse_o), 32'h0);
    check_eq("mr_valid", 32'(valid_o), 32'h0);
    check_eq("mr_ovf", 32'(overflow_o), 32'h0);
    check_eq("mr_busy", 32'(busy_o), 32'h0);
    tick(8);
    check_eq("mr_busy_keyheld", 32'(busy_o), 32'h0);
    key_i = 1'b0;
    tick(4);
    press(8);
    tick(18);
    check_eq("mr_next_valid", 32'(valid_o), 32'h1);
    check_eq("mr_next_morse", 32'(morse_o), 32'(10'b1000000000));
    ack_pulse();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/morse_capture.md
MORSE_CAPTURE -- requirements
Module: morse_capture

Interface
REQ-001 The block SHALL have the parameter MIN_PRESS, default 2, meaning the minimum key-high cycles for a press to count as a symbol.
REQ-002 The block SHALL have the parameter LONG_MIN, default 8, meaning the key-high cycles at or above which a symbol is long.
REQ-003 The block SHALL have the parameter CHAR_GAP, default 16, meaning the consecutive key-low cycles that end a character.
REQ-004 The block SHALL have the parameter CNT_W, default 24, meaning the duration counter width.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key  input  1  asynchronous telegraph key; 1 = pressed.
REQ-008 ack  input  1  consumer accepts the presented character; sampled only while valid=1.
REQ-009 morse  output  10  captured character: 5 slots of 2 bits; slot 0 (first symbol) is [9:8], slot 4 is [1:0].
REQ-010 valid  output  1  morse/overflow hold a complete character.
REQ-011 overflow  output  1  character had more than 5 symbols; extra symbols were dropped.
REQ-012 busy  output  1  a character is being assembled (state PRESS or GAP).

Function
REQ-013 The slot encodings SHALL be 00 none, 01 short, 10 long; 11 is never produced.
REQ-014 key SHALL pass through a 2-flop synchronizer; key_s denotes its output, and all timing SHALL be measured on key_s.
REQ-015 The FSM SHALL have the states IDLE, PRESS, GAP and HOLD.
REQ-016 IDLE: a key_s rising edge SHALL move to PRESS with the duration count at 1 and the slot index at 0.
REQ-017 PRESS: the count SHALL increment each cycle key_s=1 and saturate at 2^CNT_W-1.
REQ-018 PRESS, on key_s falling: a count < MIN_PRESS SHALL be discarded (glitch); a count >= LONG_MIN SHALL write 10; otherwise 01 SHALL be written.
REQ-019 The symbol SHALL be written to the slot at the index, the index SHALL then increment, and the FSM SHALL go to GAP with the count cleared.
REQ-020 A symbol arriving when the index is 5 SHALL not be written and SHALL set an internal overflow flag.
REQ-021 GAP: the low count SHALL increment each cycle key_s=0.
REQ-022 GAP, key_s rising before the low count reaches CHAR_GAP: the FSM SHALL return to PRESS with the count at 1.
REQ-023 GAP, low count = CHAR_GAP: if at least one symbol was stored, the FSM SHALL go to HOLD, with valid=1 and overflow = flag on the next cycle; otherwise it SHALL go to IDLE silently.
REQ-024 HOLD: morse, overflow and valid SHALL stay stable; key activity SHALL be ignored.
REQ-025 HOLD with ack=1: the next cycle SHALL have valid=0, all slots cleared, the flag cleared, and state IDLE.
REQ-026 Leaving HOLD: if key_s=1 at that moment, IDLE SHALL wait for a fresh rising edge, and no partial press SHALL be captured.
REQ-027 ack while valid=0 SHALL be ignored.
REQ-028 A glitch-only sequence (all presses < MIN_PRESS) SHALL never assert valid.
REQ-029 busy SHALL equal 1 exactly in PRESS and GAP.

Reset
REQ-030 On reset=1 at a clk edge: state IDLE, morse=0, valid=0, overflow=0, busy=0, counters=0, index=0, and synchronizer flops=0.
REQ-031 Reset mid-character or during HOLD SHALL discard all partial or held data with no valid pulse.
REQ-032 After reset deasserts with key held high, no symbol SHALL be captured until key_s falls and rises again.

Structure
REQ-033 Shared package morse_pkg SHALL hold SYM_NONE/SYM_SHORT/SYM_LONG (2-bit), MAX_SYMBOLS=5, MORSE_W=10 and the FSM state typedef; the same encoding SHALL be used by the morse playback path.
REQ-034 Sub-module sync2 (2-flop synchronizer with synchronous reset) SHALL be instantiated for key; the rest SHALL be flat.

Verification (MIN_PRESS=2, LONG_MIN=8, CHAR_GAP=16)
REQ-035 Press 3, release 4, press 10, release 20 -> morse=10'b0110000000, valid=1 on the cycle after the 16th low key_s cycle, and it SHALL hold until ack.
REQ-036 6 presses of 3 cycles, 4-cycle gaps -> morse=10'b0101010101, overflow=1.
REQ-037 1-cycle pulse then 20 low -> valid never asserts; busy returns to 0.
REQ-038 Press 7 vs press 8 -> slot0=01 vs slot0=10 (LONG_MIN boundary); low gap 15 then press -> same character, while gap 16 -> new character.
REQ-039 Key pressed during HOLD and still high at ack -> valid drops, and no symbol SHALL be captured from that press.
REQ-040 reset pulsed mid-PRESS after 2 stored symbols -> all outputs 0, and the next character starts at slot 0.
